// File: rtl/gen_fifo_dac_reader.sv
// gen_fifo_dac_reader: read side of the generator sample FIFO.
// Pops signed fixed-point samples, saturates them to [-1.0, 1.0), converts
// them to offset-binary DAC codes and shifts each code out MSB-first on a
// 3-wire serial link (cs_n / sclk / sdo).
module gen_fifo_dac_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int INT_BITS   = 4,
   parameter int DAC_BITS   = 16,
   parameter int CLK_DIV    = 4,
   parameter int CS_GAP     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  dac_cs_n,
   output logic                  dac_sclk,
   output logic                  dac_sdo,
   output logic                  busy,
   output logic                  clip,
   output logic [15:0]           sample_cnt
);

   localparam int FRAC  = DATA_WIDTH - INT_BITS;
   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam int BIT_W = $clog2(DAC_BITS);
   localparam int GAP_W = $clog2(CS_GAP + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DAC_BITS - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

   // 1.0 in the sample format, widened by one bit so s + 1.0 cannot overflow
   localparam logic signed [DATA_WIDTH:0] ONE = {{INT_BITS{1'b0}}, 1'b1, {FRAC{1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPT,
      SHIFT,
      GAP
   } state_t;

   state_t                 state, state_next;
   logic [DIV_W-1:0]       div_cnt, div_next;
   logic [BIT_W-1:0]       bit_cnt, bit_next;
   logic [GAP_W-1:0]       gap_cnt, gap_next;
   logic [DAC_BITS-1:0]    shreg, shreg_next;

   logic signed [DATA_WIDTH:0] s_ext;
   logic signed [DATA_WIDTH:0] sum;
   logic                       sat_hi;
   logic                       sat_lo;
   logic [DAC_BITS-1:0]        code;
   logic                       sum_unused;

   logic                       rd_en_next;
   logic                       cs_n_next;
   logic                       sclk_next;
   logic                       sdo_next;
   logic                       busy_next;
   logic                       clip_next;
   logic [15:0]                cnt_next;

   // Saturate the incoming sample and convert it to an offset-binary code
   always_comb begin
      s_ext  = {fifo_rdata[DATA_WIDTH-1], fifo_rdata};
      sum    = s_ext + ONE;
      sat_hi = (s_ext >= ONE);
      sat_lo = (s_ext < -ONE);
      if (sat_hi) begin
         code = '1;
      end else if (sat_lo) begin
         code = '0;
      end else begin
         code = sum[FRAC -: DAC_BITS];
      end
   end

   assign sum_unused = ^sum;

   // State, frame counters, shift register and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
         shreg      <= '0;
         fifo_rd_en <= 1'b0;
         dac_cs_n   <= 1'b1;
         dac_sclk   <= 1'b0;
         dac_sdo    <= 1'b0;
         busy       <= 1'b0;
         clip       <= 1'b0;
         sample_cnt <= '0;
      end else begin
         state      <= state_next;
         div_cnt    <= div_next;
         bit_cnt    <= bit_next;
         gap_cnt    <= gap_next;
         shreg      <= shreg_next;
         fifo_rd_en <= rd_en_next;
         dac_cs_n   <= cs_n_next;
         dac_sclk   <= sclk_next;
         dac_sdo    <= sdo_next;
         busy       <= busy_next;
         clip       <= clip_next;
         sample_cnt <= cnt_next;
      end
   end

   // Next-state and counter sequencing: IDLE -> READ -> CAPT -> SHIFT -> GAP
   always_comb begin
      state_next = state;
      div_next   = div_cnt;
      bit_next   = bit_cnt;
      gap_next   = gap_cnt;
      shreg_next = shreg;
      case (state)
         IDLE: begin
            if (en && !fifo_empty) begin
               state_next = READ;
            end
         end
         READ: begin
            state_next = CAPT;
         end
         CAPT: begin
            state_next = SHIFT;
            div_next   = '0;
            bit_next   = '0;
            shreg_next = code;
         end
         SHIFT: begin
            if (div_cnt == DIV_LAST) begin
               div_next = '0;
               if (bit_cnt == BIT_LAST) begin
                  state_next = GAP;
                  gap_next   = '0;
                  shreg_next = '0;
               end else begin
                  bit_next   = bit_cnt + 1'b1;
                  shreg_next = {shreg[DAC_BITS-2:0], 1'b0};
               end
            end else begin
               div_next = div_cnt + 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_next = IDLE;
            end else begin
               gap_next = gap_cnt + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output values for the coming cycle; derived from next-state values so
   // that the registered outputs line up with the state they belong to
   always_comb begin
      rd_en_next = (state_next == READ);
      cs_n_next  = (state_next != SHIFT);
      sclk_next  = (state_next == SHIFT) && (div_next >= DIV_HALF);
      sdo_next   = (state_next == SHIFT) && shreg_next[DAC_BITS-1];
      busy_next  = (state_next != IDLE);
      clip_next  = (state == CAPT) && (sat_hi || sat_lo);
      cnt_next   = sample_cnt;
      if ((state == SHIFT) && (state_next == GAP)) begin
         cnt_next = sample_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_gen_fifo_dac_reader.sv
// tb_gen_fifo_dac_reader: randomized self-checking bench for gen_fifo_dac_reader.
// A queue-based FIFO feeds the DUT; every pushed word also gets its expected
// DAC code and clip flag from an arithmetic model, and a frame decoder
// reassembles the serial link and compares whole frames.
module tb_gen_fifo_dac_reader;

   localparam int DW       = 32;
   localparam int FRAC     = 28;
   localparam int DACB     = 16;
   localparam int CDIV     = 4;
   localparam int CSGAP    = 2;
   localparam int LOW_LEN  = DACB * 2 * CDIV;
   localparam int PERIOD   = 3 + LOW_LEN + CSGAP;

   logic          clk;
   logic          rst;
   logic          en;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rdata;
   logic          dac_cs_n;
   logic          dac_sclk;
   logic          dac_sdo;
   logic          busy;
   logic          clip;
   logic [15:0]   sample_cnt;

   gen_fifo_dac_reader #(
      .DATA_WIDTH (DW),
      .INT_BITS   (4),
      .DAC_BITS   (DACB),
      .CLK_DIV    (CDIV),
      .CS_GAP     (CSGAP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_rdata (fifo_rdata),
      .dac_cs_n   (dac_cs_n),
      .dac_sclk   (dac_sclk),
      .dac_sdo    (dac_sdo),
      .busy       (busy),
      .clip       (clip),
      .sample_cnt (sample_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] fifo_q[$];
   logic [15:0]   exp_code[$];
   int            exp_clip[$];
   int            falls[$];
   logic          pop_pend = 1'b0;

   int            cyc         = 0;
   logic          prev_cs     = 1'b1;
   logic          prev_sclk   = 1'b0;
   int            nbits       = 0;
   logic [15:0]   bits        = '0;
   int            low_len     = 0;
   int            high_len    = 0;
   int            clip_acc    = 0;
   int            idle_glitch = 0;
   int            frames      = 0;
   int            frames_seen = 0;
   logic          in_frame    = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected DAC code for a sample: clamp to [-1.0, 1.0), shift by +1.0, keep top bits
   task automatic model(input logic [DW-1:0] w, output logic [15:0] code, output int c);
      longint s;
      longint one;
      s   = longint'($signed(w));
      one = longint'(1) << FRAC;
      if (s >= one) begin
         code = 16'hFFFF;
         c    = 1;
      end else if (s < -one) begin
         code = 16'h0000;
         c    = 1;
      end else begin
         code = 16'((s + one) >> (FRAC - DACB + 1));
         c    = 0;
      end
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      logic [15:0] code;
      int          c;
      model(w, code, c);
      fifo_q.push_back(w);
      exp_code.push_back(code);
      exp_clip.push_back(c);
      fifo_empty = 1'b0;
   endtask

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] edges [7];
      edges = '{32'h1000_0000, 32'h0FFF_FFFF, 32'hF000_0000, 32'hEFFF_FFFF,
                32'h1000_0001, 32'h7FFF_FFFF, 32'h8000_0000};
      case ($urandom_range(0, 3))
         0:       return $urandom();
         1:       return $urandom_range(0, 32'h1FFF_FFFF) - 32'h1000_0000;
         2:       return edges[$urandom_range(0, 6)];
         default: return $urandom_range(0, 32'h0001_FFFF) - 32'h0001_0000;
      endcase
   endfunction

   // One clock: advance FIFO model, then decode the serial link
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (pop_pend) begin
         fifo_rdata = fifo_q.pop_front();
         pop_pend   = 1'b0;
      end else begin
         fifo_rdata = $urandom();
      end
      fifo_empty = (fifo_q.size() == 0);
      if (fifo_rd_en) begin
         if (fifo_q.size() == 0) begin
            check_eq("pop_of_empty", 32'(fifo_empty), 32'(0));
         end else begin
            pop_pend = 1'b1;
         end
      end

      if (prev_cs && !dac_cs_n) begin
         in_frame = 1'b1;
         nbits    = 0;
         bits     = '0;
         low_len  = 0;
         high_len = 0;
         falls.push_back(cyc);
      end
      if (!dac_cs_n) begin
         low_len++;
         if (dac_sclk) high_len++;
         if (!prev_sclk && dac_sclk) begin
            bits = {bits[14:0], dac_sdo};
            nbits++;
         end
      end else if (dac_sclk || dac_sdo) begin
         idle_glitch++;
      end
      if (clip) clip_acc++;

      if (!prev_cs && dac_cs_n && in_frame) begin
         in_frame = 1'b0;
         frames++;
         frames_seen++;
         check_eq("frame_bits", 32'(nbits), 32'(DACB));
         check_eq("cs_low_len", 32'(low_len), 32'(LOW_LEN));
         check_eq("sclk_high_len", 32'(high_len), 32'(DACB * CDIV));
         check_eq("sclk_end_low", 32'(dac_sclk), 32'(0));
         check_eq("idle_glitch", 32'(idle_glitch), 32'(0));
         check_eq("sample_cnt", 32'(sample_cnt), 32'(16'(frames)));
         if (exp_code.size() == 0) begin
            check_eq("unexpected_frame", 32'(1), 32'(0));
         end else begin
            check_eq("code", 32'(bits), 32'(exp_code.pop_front()));
            check_eq("clip", 32'(clip_acc), 32'(exp_clip.pop_front()));
         end
         clip_acc    = 0;
         idle_glitch = 0;
      end
      prev_cs   = dac_cs_n;
      prev_sclk = dac_sclk;
   endtask

   task automatic run_frames(input int target, input int budget);
      int n;
      n = 0;
      while (frames_seen < target && n < budget) begin
         step();
         n++;
      end
      check_eq("frames_reached", 32'(frames_seen), 32'(target));
   endtask

   int base;
   int rd_cnt;
   int busy_cnt;
   int n;
   int batch;

   initial begin
      rst        = 1'b1;
      en         = 1'b0;
      fifo_empty = 1'b1;
      fifo_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rd_en", 32'(fifo_rd_en), 32'(0));
      check_eq("rst_cs_n", 32'(dac_cs_n), 32'(1));
      check_eq("rst_sclk", 32'(dac_sclk), 32'(0));
      check_eq("rst_sdo", 32'(dac_sdo), 32'(0));
      check_eq("rst_busy", 32'(busy), 32'(0));
      check_eq("rst_clip", 32'(clip), 32'(0));
      check_eq("rst_sample_cnt", 32'(sample_cnt), 32'(0));
      rst = 1'b0;

      // Empty FIFO with en high: no pop, no activity
      en       = 1'b1;
      rd_cnt   = 0;
      busy_cnt = 0;
      repeat (50) begin
         step();
         if (fifo_rd_en) rd_cnt++;
         if (busy) busy_cnt++;
      end
      check_eq("empty_no_pop", 32'(rd_cnt), 32'(0));
      check_eq("empty_not_busy", 32'(busy_cnt), 32'(0));

      // Three queued words back-to-back
      base = falls.size();
      push_word(32'h0000_0000);
      push_word(32'h1000_0000);
      push_word(32'h0FFF_FFFF);
      run_frames(frames_seen + 3, 3 * PERIOD + 50);
      if (falls.size() >= base + 3) begin
         check_eq("frame_period_1", 32'(falls[base + 1] - falls[base]), 32'(PERIOD));
         check_eq("frame_period_2", 32'(falls[base + 2] - falls[base + 1]), 32'(PERIOD));
      end else begin
         check_eq("frame_starts", 32'(falls.size() - base), 32'(3));
      end
      check_eq("sample_cnt_3", 32'(sample_cnt), 32'(3));

      // Remaining conversion corners
      push_word(32'hE000_0000);
      push_word(32'hF000_0000);
      push_word(32'h0800_0000);
      push_word(32'hF800_0000);
      run_frames(frames_seen + 4, 4 * PERIOD + 50);

      // en dropped during frame 2 of 3
      base = frames_seen;
      for (int i = 0; i < 3; i++) push_word(rand_word());
      n = 0;
      begin
         int target;
         target = falls.size() + 2;
         while (falls.size() < target && n < 3 * PERIOD) begin
            step();
            n++;
         end
         check_eq("second_frame_start", 32'(falls.size()), 32'(target));
      end
      en = 1'b0;
      run_frames(base + 2, 2 * PERIOD + 50);
      repeat (200) step();
      check_eq("held_frames", 32'(frames_seen), 32'(base + 2));
      check_eq("held_fifo_level", 32'(fifo_q.size()), 32'(1));
      check_eq("held_busy", 32'(busy), 32'(0));
      en = 1'b1;
      run_frames(base + 3, PERIOD + 50);

      // Randomized batches with occasional en pauses
      for (int b = 0; b < 12; b++) begin
         batch = $urandom_range(1, 4);
         for (int i = 0; i < batch; i++) push_word(rand_word());
         if ($urandom_range(0, 2) == 0) begin
            en = 1'b0;
            repeat ($urandom_range(1, 20)) step();
            en = 1'b1;
         end
         run_frames(frames_seen + batch, batch * PERIOD + 100);
      end

      // Reset in the middle of a frame
      push_word(rand_word());
      push_word(32'h0400_0000);
      n = 0;
      while (!(in_frame && nbits >= 5) && n < 2 * PERIOD) begin
         step();
         n++;
      end
      check_eq("reached_bit5", 32'(nbits), 32'(5));
      #1 rst = 1'b1;
      #1;
      check_eq("async_cs_n", 32'(dac_cs_n), 32'(1));
      check_eq("async_sclk", 32'(dac_sclk), 32'(0));
      check_eq("async_sample_cnt", 32'(sample_cnt), 32'(0));
      check_eq("async_busy", 32'(busy), 32'(0));
      #1 rst = 1'b0;
      void'(exp_code.pop_front());
      void'(exp_clip.pop_front());
      in_frame    = 1'b0;
      prev_cs     = 1'b1;
      prev_sclk   = 1'b0;
      clip_acc    = 0;
      idle_glitch = 0;
      frames      = 0;
      pop_pend    = 1'b0;
      run_frames(frames_seen + 1, PERIOD + 50);
      check_eq("after_rst_cnt", 32'(sample_cnt), 32'(1));

      check_eq("exp_drained", 32'(exp_code.size()), 32'(0));
      check_eq("fifo_drained", 32'(fifo_q.size()), 32'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
